// File: rtl/exec_div_sequencer.sv
// rtl/exec_div_sequencer.sv - multi-cycle divide sequencer for the Execute stage (optional watchdog: DIV_TIMEOUT_EN)
module exec_div_sequencer #(
  parameter int TIMEOUT_CYCLES = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic IssueValid,
  input  logic IsDiv,
  input  logic Flush,
  input  logic ExtStall,
  input  logic DivReady,
  output logic DivStart,
  output logic StallOut,
  output logic ResultValid,
  output logic Busy,
  output logic Timeout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   launch;
  logic   wd_fire;
  logic   div_start;
  logic   stall_out;
  logic   result_valid;

  // The watchdog limit must fit the 5-bit counter and leave at least two WAIT cycles.
  if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 31)) begin : g_bad_timeout
    $error("exec_div_sequencer: TIMEOUT_CYCLES must be within 2..31");
  end

  // Next-state and per-state outputs; Flush always takes priority over progress.
  always_comb begin
    launch       = IssueValid & IsDiv & ~Flush & ~ExtStall;
    state_d      = state_q;
    div_start    = 1'b0;
    stall_out    = 1'b0;
    result_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall_out = launch;
        if (launch) state_d = S_START;
      end
      S_START: begin
        div_start = 1'b1;
        stall_out = 1'b1;
        state_d   = Flush ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        stall_out = 1'b1;
        if (Flush)                    state_d = S_IDLE;
        else if (DivReady | wd_fire)  state_d = S_DONE;
      end
      S_DONE: begin
        result_valid = ~Flush;
        if (Flush | ~ExtStall) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset abandons any divide in flight.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

`ifdef DIV_TIMEOUT_EN
  localparam logic [4:0] WdLimit = 5'(TIMEOUT_CYCLES);

  logic [4:0] wd_cnt_q, wd_cnt_d;
  logic       timeout_q, timeout_d;

  // Watchdog: counter restarts in START, counts WAIT cycles, and forces DONE at the limit.
  always_comb begin
    wd_cnt_d  = wd_cnt_q;
    timeout_d = timeout_q;
    wd_fire   = 1'b0;
    if (state_q == S_START) begin
      wd_cnt_d = 5'd0;
    end else if (state_q == S_WAIT) begin
      wd_cnt_d = wd_cnt_q + 5'd1;
      wd_fire  = (wd_cnt_d == WdLimit) & ~DivReady;
      if (wd_fire & ~Flush) timeout_d = 1'b1;
    end
  end

  // Watchdog counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wd_cnt_q  <= 5'd0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign Timeout = rst & timeout_q;
`else
  assign wd_fire = 1'b0;
  assign Timeout = 1'b0;
`endif

  // All outputs are held low while reset is asserted, whatever the inputs do.
  assign DivStart    = rst & div_start;
  assign StallOut    = rst & stall_out;
  assign ResultValid = rst & result_valid;
  assign Busy        = rst & (state_q != S_IDLE);

endmodule

// File: tb/tb_exec_div_sequencer.sv
// tb/tb_exec_div_sequencer.sv - self-checking bench for exec_div_sequencer
module tb_exec_div_sequencer;

  localparam int TO_CYCLES = 24;
`ifdef DIV_TIMEOUT_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, IssueValid, IsDiv, Flush, ExtStall, DivReady;
  logic DivStart, StallOut, ResultValid, Busy, Timeout;

  exec_div_sequencer #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (
    .clk(clk), .rst(rst), .IssueValid(IssueValid), .IsDiv(IsDiv), .Flush(Flush),
    .ExtStall(ExtStall), .DivReady(DivReady), .DivStart(DivStart), .StallOut(StallOut),
    .ResultValid(ResultValid), .Busy(Busy), .Timeout(Timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a divide transaction with an age since acceptance.
  bit m_active;  // a divide has been accepted and not yet retired
  bit m_result;  // the divider answer (or watchdog result) is being presented
  bit m_to;      // sticky watchdog flag
  int m_age;     // cycles since acceptance; age 1 is the launch cycle

  // Per-scenario observation counters.
  int t, n_start, n_rv, t_start, t_rv;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b (step %0d)", tag, obs, exp, t);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic mark();
    t = 0; n_start = 0; n_rv = 0; t_start = -1; t_rv = -1;
  endtask

  // One clock cycle: drive, check outputs against the model, then advance the model.
  task automatic step(input bit r, input bit iv, input bit isd, input bit fl, input bit es, input bit dr);
    bit launch, e_start, e_stall, e_rv, e_busy, e_to;
    @(negedge clk);
    rst = r; IssueValid = iv; IsDiv = isd; Flush = fl; ExtStall = es; DivReady = dr;
    #1;
    launch  = !m_active && iv && isd && !fl && !es;
    e_start = r && m_active && (m_age == 1);
    e_stall = r && (launch || (m_active && !m_result));
    e_rv    = r && m_active && m_result && !fl;
    e_busy  = r && m_active;
    e_to    = r && m_to;
    check("DivStart", DivStart, e_start);
    check("StallOut", StallOut, e_stall);
    check("ResultValid", ResultValid, e_rv);
    check("Busy", Busy, e_busy);
    check("Timeout", Timeout, e_to);
    if (DivStart === 1'b1) begin n_start++; t_start = t; end
    if (ResultValid === 1'b1) begin n_rv++; t_rv = t; end
    t++;
    @(posedge clk);
    if (!r) begin
      m_active = 1'b0; m_result = 1'b0; m_to = 1'b0; m_age = 0;
    end else if (!m_active) begin
      if (launch) begin m_active = 1'b1; m_result = 1'b0; m_age = 1; end
    end else if (m_result) begin
      if (fl || !es) m_active = 1'b0;
    end else if (m_age == 1) begin
      if (fl) m_active = 1'b0; else m_age = 2;
    end else begin
      if (fl) m_active = 1'b0;
      else if (dr) m_result = 1'b1;
      else if (WD_ON && (m_age - 1 == TO_CYCLES)) begin m_result = 1'b1; m_to = 1'b1; end
      else m_age++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int d;
    m_active = 0; m_result = 0; m_to = 0; m_age = 0;
    mark();

    // Reset with every input asserted: outputs stay low.
    step(0, 1, 1, 1, 1, 1);
    step(0, 1, 1, 0, 0, 1);

    // Nominal divide, DivReady 17 cycles after DivStart.
    mark();
    step(1, 1, 1, 0, 0, 0);
    idle(17);
    step(1, 0, 0, 0, 0, 1);
    idle(2);
    check_int("nominal_divstart_cycle", t_start, 1);
    check_int("nominal_result_cycle", t_rv, 19);
    check_int("nominal_result_count", n_rv, 1);

    // Non-div or stalled issue does not launch.
    mark();
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 1, 0);
    step(1, 1, 1, 1, 0, 0);
    check_int("no_launch_starts", n_start, 0);

    // Flush 5 cycles into WAIT, late DivReady ignored.
    mark();
    step(1, 1, 1, 0, 0, 0);
    idle(6);
    step(1, 0, 0, 1, 0, 0);
    idle(9);
    step(1, 0, 0, 0, 0, 1);
    idle(3);
    check_int("flush_starts", n_start, 1);
    check_int("flush_results", n_rv, 0);

    // ExtStall holds DONE for 3 extra cycles.
    mark();
    step(1, 1, 1, 0, 0, 0);
    idle(4);
    step(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    idle(2);
    check_int("extstall_result_cycles", n_rv, 4);

    // DivReady never arrives: watchdog (if built) forces DONE after TO_CYCLES WAIT cycles.
    mark();
    step(1, 1, 1, 0, 0, 0);
    idle(35);
    check_int("watchdog_result_cycle", t_rv, WD_ON ? TO_CYCLES + 2 : -1);
    step(1, 0, 0, 1, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    idle(3);
    step(1, 0, 0, 0, 0, 1);
    idle(2);
    step(0, 0, 0, 0, 0, 0);
    idle(1);

    // Reset mid-WAIT, stale DivReady ignored, then two back-to-back divides.
    mark();
    step(1, 1, 1, 0, 0, 0);
    idle($urandom_range(2, 6));
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 1);
    check_int("reset_abort_results", n_rv, 0);
    mark();
    step(1, 1, 1, 0, 0, 0);
    d = $urandom_range(1, 8);
    idle(d);
    step(1, 0, 0, 0, 0, 1);
    step(1, 1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    idle($urandom_range(1, 8));
    step(1, 0, 0, 0, 0, 1);
    idle(2);
    check_int("b2b_starts", n_start, 2);
    check_int("b2b_results", n_rv, 2);

    // Randomized soak against the model.
    for (int i = 0; i < 3000; i++)
      step(($urandom % 64) != 0, $urandom % 2, ($urandom % 4) != 0,
           ($urandom % 16) == 0, ($urandom % 4) == 0, ($urandom % 8) == 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/exec_div_sequencer.md
EXEC_DIV_SEQUENCER -- requirements
Module: exec_div_sequencer

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 24, number of WAIT cycles before the watchdog fires (legal range 2..31).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-low.
REQ-004 IssueValid  input  1  valid instruction present in Execute this cycle.
REQ-005 IsDiv  input  1  instruction in Execute is a multi-cycle divide (ALUOp select for divider).
REQ-006 Flush  input  1  squash instruction in Execute (branch mispredict/exception).
REQ-007 ExtStall  input  1  downstream (Memory) stall; pipeline frozen this cycle.
REQ-008 DivReady  input  1  divider result and remainder valid (from ALU).
REQ-009 DivStart  output  1  one-cycle pulse launching the divider.
REQ-010 StallOut  output  1  drives Execute/Decode/Fetch stall inputs while divide is in flight.
REQ-011 ResultValid  output  1  quotient/remainder may be captured by the Execute register this cycle.
REQ-012 Busy  output  1  sequencer not in IDLE.
REQ-013 Timeout  output  1  sticky watchdog error flag.

Function
REQ-014 FSM states SHALL be IDLE, START, WAIT, DONE, encoded in a registered 2-bit state.
REQ-015 IDLE -> START when IssueValid & IsDiv & !Flush & !ExtStall; otherwise stay IDLE.
REQ-016 StallOut SHALL be combinational: 1 in IDLE when the REQ-015 launch condition holds, 1 in START, 1 in WAIT, 0 in DONE and otherwise.
REQ-017 In START, DivStart SHALL be 1 for exactly that cycle; START -> WAIT unconditionally unless Flush.
REQ-018 In WAIT, DivReady=1 -> DONE next cycle; DivReady sampled only in WAIT, ignored in all other states.
REQ-019 In DONE, ResultValid = !Flush; DONE -> IDLE when !ExtStall; DONE holds (ResultValid kept high) while ExtStall=1.
REQ-020 Divide latency: DivStart one cycle after issue; ResultValid one cycle after DivReady; minimum issue-to-ResultValid 3 cycles.
REQ-021 Flush in START or WAIT SHALL return to IDLE next cycle without DivStart re-issue; a late DivReady from the aborted divide SHALL be ignored.
REQ-022 Flush in DONE SHALL force ResultValid=0 that cycle and return to IDLE.
REQ-023 Back-to-back divides: a divide issued the cycle after DONE exit SHALL launch normally from IDLE; no divide is launched from DONE.
REQ-024 Busy = (state != IDLE), registered-state derived, no input dependence.
REQ-025 Simultaneous DivReady and Flush in WAIT: Flush wins, next state IDLE.

Reset
REQ-026 While rst=0 at a clock edge: state=IDLE, watchdog counter=0, Timeout=0.
REQ-027 While rst=0, all outputs SHALL be 0 regardless of inputs; reset mid-divide abandons the operation, later DivReady ignored.

Configuration
REQ-028 Macro DIV_TIMEOUT_EN: when defined, a 5-bit counter clears on entering WAIT, increments each WAIT cycle, and when it reaches TIMEOUT_CYCLES without DivReady the FSM goes to DONE with ResultValid=1 and Timeout set to 1 (sticky until reset).
REQ-029 Without DIV_TIMEOUT_EN: no counter is built, Timeout is tied to 0, WAIT is left only by DivReady, Flush or reset.

Verification
REQ-030 Issue divide, DivReady 17 cycles after DivStart, no stalls -> DivStart at cycle 1, StallOut 1 cycles 0..18, ResultValid 1 at cycle 19 only, Busy 0 at cycle 20.
REQ-031 Flush 5 cycles into WAIT, DivReady 10 cycles later -> IDLE after flush, no ResultValid, no second DivStart.
REQ-032 DivReady then ExtStall=1 for 3 cycles in DONE -> ResultValid held 4 cycles, StallOut 0, IDLE after ExtStall drops.
REQ-033 With DIV_TIMEOUT_EN, TIMEOUT_CYCLES=24, DivReady never asserted -> DONE after 24 WAIT cycles, Timeout=1 and stays 1 across following divides until rst=0.
REQ-034 rst=0 asserted in WAIT for one cycle -> state IDLE, all outputs 0, subsequent DivReady ignored; two back-to-back divides afterwards each produce exactly one DivStart and one ResultValid.
